// File: rtl/jk_cmd_gen.sv
// rtl/jk_cmd_gen.sv - two-button debounced J/K command generator for a JK flip-flop
module jk_cmd_gen #(
    parameter int DEB_CYCLES = 4,
    parameter int PAIR_WIN   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_j_i,
    input  logic btn_k_i,
    output logic j_o,
    output logic k_o,
    output logic deb_j_o,
    output logic deb_k_o,
    output logic busy_o
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int WW = $clog2(PAIR_WIN + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(PAIR_WIN - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PAIR_J   = 3'd1,
        PAIR_K   = 3'd2,
        EMIT     = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    // Bit 1 carries the J button, bit 0 the K button, matching the {j,k} command code.
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    deb_q;
    logic [1:0]    deb_dly_q;
    logic [DW-1:0] cnt_q [2];
    logic [1:0]    rise;

    state_t        state_q, state_d;
    logic [WW-1:0] win_q, win_d;
    logic [1:0]    cmd_q, cmd_d;
    logic          j_q, k_q, busy_q;
    logic          j_d, k_d, busy_d;

    // Two-flop synchronisers, per-button debounce counters and the delayed debounced level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            sync1_q   <= {btn_j_i, btn_k_i};
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DEB_LAST) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign rise = deb_q & ~deb_dly_q;

    // FSM state, pairing window and latched command.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            win_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
        end
    end

    // Next state: pair near-simultaneous presses, otherwise commit a lone press on release or window expiry.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: begin
                if (rise == 2'b11) begin
                    cmd_d   = 2'b11;
                    state_d = EMIT;
                end else if (rise[1]) begin
                    win_d   = '0;
                    state_d = PAIR_J;
                end else if (rise[0]) begin
                    win_d   = '0;
                    state_d = PAIR_K;
                end
            end
            PAIR_J: begin
                if (deb_q[0]) begin
                    cmd_d   = 2'b11;
                    state_d = EMIT;
                end else if (!deb_q[1] || win_q == WIN_LAST) begin
                    cmd_d   = 2'b10;
                    state_d = EMIT;
                end else begin
                    win_d = win_q + WW'(1);
                end
            end
            PAIR_K: begin
                if (deb_q[1]) begin
                    cmd_d   = 2'b11;
                    state_d = EMIT;
                end else if (!deb_q[0] || win_q == WIN_LAST) begin
                    cmd_d   = 2'b01;
                    state_d = EMIT;
                end else begin
                    win_d = win_q + WW'(1);
                end
            end
            EMIT: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so the registered pulse coincides with the EMIT cycle.
    always_comb begin
        j_d    = 1'b0;
        k_d    = 1'b0;
        busy_d = (state_d != IDLE);
        if (state_d == EMIT) begin
            j_d = cmd_d[1];
            k_d = cmd_d[0];
        end
    end

    // Output registers; reset clears any pulse in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            j_q    <= 1'b0;
            k_q    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            j_q    <= j_d;
            k_q    <= k_d;
            busy_q <= busy_d;
        end
    end

    assign j_o     = j_q;
    assign k_o     = k_q;
    assign busy_o  = busy_q;
    assign deb_j_o = deb_q[1];
    assign deb_k_o = deb_q[0];

endmodule

// File: tb/tb_jk_cmd_gen.sv
// tb/tb_jk_cmd_gen.sv - self-checking bench for jk_cmd_gen
module tb_jk_cmd_gen;

    localparam int DEB = 4;
    localparam int PW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bj  = 1'b0;
    logic bk  = 1'b0;
    logic j, k, dj, dk, busy;

    always #5 clk = ~clk;

    jk_cmd_gen #(.DEB_CYCLES(DEB), .PAIR_WIN(PW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_j_i (bj),
        .btn_k_i (bk),
        .j_o     (j),
        .k_o     (k),
        .deb_j_o (dj),
        .deb_k_o (dk),
        .busy_o  (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_total = 0;
    int pulse_cyc   = 0;
    logic [1:0] pulse_val = 2'b00;
    int debj_rises = 0;
    logic prev_dj = 1'b0;
    logic q = 1'b0;
    logic [1:0] last_out = 2'b00;

    // Reference model: index 1 = J, index 0 = K. Phases: 0 idle, 1 pairing, 2 emit, 3 wait release.
    logic [1:0] m_s1 = 0, m_s = 0, m_deb = 0, m_debd = 0;
    int m_run [2] = '{0, 0};
    int m_phase = 0, m_owner = 0, m_age = 0;
    logic [1:0] m_cmd = 0, m_out = 0;
    logic m_busy = 0;

    task automatic model_step();
        logic [1:0] raw, rise, deb_old;
        raw = {bj, bk};
        if (rst) begin
            m_s1 = 0; m_s = 0; m_deb = 0; m_debd = 0;
            m_run[0] = 0; m_run[1] = 0;
            m_phase = 0; m_owner = 0; m_age = 0;
            m_cmd = 0; m_out = 0; m_busy = 0;
            return;
        end
        deb_old = m_deb;
        rise = m_deb & ~m_debd;
        case (m_phase)
            0: begin
                if (rise == 2'b11) begin m_cmd = 2'b11; m_phase = 2; end
                else if (rise[1]) begin m_owner = 1; m_age = 0; m_phase = 1; end
                else if (rise[0]) begin m_owner = 0; m_age = 0; m_phase = 1; end
            end
            1: begin
                if (deb_old[1 - m_owner]) begin
                    m_cmd = 2'b11; m_phase = 2;
                end else if (!deb_old[m_owner] || m_age == PW - 1) begin
                    m_cmd = (m_owner == 1) ? 2'b10 : 2'b01; m_phase = 2;
                end else begin
                    m_age++;
                end
            end
            2: m_phase = 3;
            default: if (deb_old == 2'b00) m_phase = 0;
        endcase
        m_out  = (m_phase == 2) ? m_cmd : 2'b00;
        m_busy = (m_phase != 0);
        for (int i = 0; i < 2; i++) begin
            if (m_s[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = m_s[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_debd = deb_old;
        m_s    = m_s1;
        m_s1   = raw;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: advance the flip-flop and model on the edge, then compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) q = 1'b0;
        else begin
            case (last_out)
                2'b10: q = 1'b1;
                2'b01: q = 1'b0;
                2'b11: q = ~q;
                default: ;
            endcase
        end
        model_step();
        cyc++;
        #1;
        total++;
        if ({j, k, dj, dk, busy} !== {m_out, m_deb, m_busy}) begin
            bad++;
            $display("FAIL model cycle %0d: got jk=%b%b deb=%b%b busy=%b expected jk=%b deb=%b busy=%b",
                     cyc, j, k, dj, dk, busy, m_out, m_deb, m_busy);
        end
        last_out = {j, k};
        if (j | k) begin
            pulse_total++;
            pulse_cyc = cyc;
            pulse_val = {j, k};
        end
        if (dj && !prev_dj) debj_rises++;
        prev_dj = dj;
    endtask

    // Drive buttons over steps [on,off) relative to the start; step n is sampled on edge n+1.
    task automatic gesture(input int jon, input int joff, input int kon, input int koff, input int len,
                           output int cnt, output int pedge, output int val);
        int b, o;
        b = pulse_total;
        o = cyc;
        for (int n = 0; n < len; n++) begin
            bj = (n >= jon && n < joff);
            bk = (n >= kon && n < koff);
            tick();
        end
        bj = 1'b0;
        bk = 1'b0;
        cnt   = pulse_total - b;
        pedge = pulse_cyc - o;
        val   = int'(pulse_val);
        repeat (15) tick();
    endtask

    initial begin
        int cnt, pedge, val, base, o, r0;
        int tj, tk;

        // Reset held with both buttons pressed, then released.
        rst = 1'b1; bj = 1'b1; bk = 1'b1;
        repeat (3) begin
            tick();
            chk("reset_outputs_zero", int'({j, k, dj, dk, busy}), 0);
        end
        rst = 1'b0;
        base = pulse_total;
        o = cyc;
        repeat (5) tick();
        chk("deb_j_low_edge5", int'(dj), 0);
        tick();
        chk("deb_j_high_edge6", int'(dj), 1);
        chk("deb_k_high_edge6", int'(dk), 1);
        repeat (10) tick();
        chk("post_reset_pulse_count", pulse_total - base, 1);
        chk("post_reset_pulse_edge", pulse_cyc - o, 7);
        chk("post_reset_pulse_val", int'(pulse_val), 3);
        bj = 1'b0; bk = 1'b0;
        repeat (12) tick();
        chk("post_reset_idle_busy", int'(busy), 0);

        // Lone J held past the window.
        gesture(0, 30, 0, 0, 40, cnt, pedge, val);
        chk("lone_j_count", cnt, 1);
        chk("lone_j_edge", pedge, 15);
        chk("lone_j_val", val, 2);
        chk("lone_j_busy_after", int'(busy), 0);
        chk("lone_j_deb_after", int'(dj), 0);

        // K first, J three cycles later.
        gesture(3, 25, 0, 25, 40, cnt, pedge, val);
        chk("pair_k3_count", cnt, 1);
        chk("pair_k3_edge", pedge, 10);
        chk("pair_k3_val", val, 3);

        // Lone K held past the window.
        gesture(0, 0, 0, 30, 40, cnt, pedge, val);
        chk("lone_k_count", cnt, 1);
        chk("lone_k_edge", pedge, 15);
        chk("lone_k_val", val, 1);

        // Three-cycle glitch on J.
        base = debj_rises;
        gesture(0, 3, 0, 0, 20, cnt, pedge, val);
        chk("glitch_count", cnt, 0);
        chk("glitch_deb_rises", debj_rises - base, 0);

        // J held six cycles: early release commits before the window expires.
        gesture(0, 6, 0, 0, 25, cnt, pedge, val);
        chk("early_rel_count", cnt, 1);
        chk("early_rel_edge", pedge, 13);
        chk("early_rel_val", val, 2);

        // Reset while pairing, button released with reset.
        base = pulse_total;
        bj = 1'b1;
        repeat (9) tick();
        chk("pairing_busy", int'(busy), 1);
        rst = 1'b1; bj = 1'b0;
        tick();
        chk("reset_mid_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (20) tick();
        chk("reset_mid_no_pulse", pulse_total - base, 0);
        chk("reset_mid_idle", int'(busy), 0);

        // Reset while pairing, button still held: fresh qualification and a new command.
        bj = 1'b1;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = pulse_total;
        o = cyc;
        repeat (20) tick();
        chk("reset_held_count", pulse_total - base, 1);
        chk("reset_held_edge", pulse_cyc - o, 15);
        bj = 1'b0;
        repeat (15) tick();

        // End to end with a JK flip-flop: two toggle gestures.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("ff_q_reset", int'(q), 0);
        gesture(0, 12, 0, 12, 25, cnt, pedge, val);
        chk("ff_q_first_toggle", int'(q), 1);
        gesture(0, 12, 0, 12, 25, cnt, pedge, val);
        chk("ff_q_second_toggle", int'(q), 0);

        // Randomised buttons with occasional reset, checked every cycle against the model.
        tj = 1; tk = 1;
        for (int n = 0; n < 4000; n++) begin
            r0 = $urandom_range(0, 399);
            rst = (r0 == 0);
            tj--;
            tk--;
            if (tj <= 0) begin
                bj = ~bj;
                tj = $urandom_range(1, 25);
                if ($urandom_range(0, 3) == 0) begin
                    bk = bj;
                    tk = tj;
                end
            end
            if (tk <= 0) begin
                bk = ~bk;
                tk = $urandom_range(1, 25);
            end
            tick();
        end
        rst = 1'b0; bj = 1'b0; bk = 1'b0;
        repeat (20) tick();
        chk("random_end_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
